pong_match_engine: RTL and testbench
====================================

# pong_match_engine

Parametrised frame-stepped game core for the ping-pong demo. It owns ball kinematics, wall and paddle collision, an automated left paddle, the two score counters and the match state machine (serve delay, point, game over). It sits between the frame-timing logic, which supplies `frame_tick`, and the renderer, which consumes positions and scores. It replaces the fixed-width single-rally top with configurable widths, win threshold and serve behaviour.

## Interface
- `COORD_W`, 16: width of each unsigned coordinate.
- `VEL_W`, 8: width of each signed velocity component.
- `SCORE_W`, 8: width of each score counter.
- `WIN_SCORE`, 11: score that ends the match; must be at most 2^SCORE_W−1.
- `PADDLE_H`, 32: paddle height in pixels.
- `PADDLE_X`, 8: distance of each paddle face from its side edge.
- `SERVE_FRAMES`, 60: number of frame ticks spent in SERVE.
- `AI_STEP`, 2: maximum left-paddle movement per frame.
- `INIT_VX`, 3 and `INIT_VY`, 2: serve speed magnitudes.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start` in 1: begins a match from IDLE or GAMEOVER.
- `dimensions` in 2*COORD_W: playfield size; `{width, height}`, with width in the upper half.
- `right_paddle_y` in COORD_W: top of the player-driven paddle.
- `ball_x`, `ball_y` out COORD_W: ball position.
- `ball_vx`, `ball_vy` out VEL_W, signed: ball velocity.
- `left_paddle_y` out COORD_W: top of the AI-driven paddle.
- `score_left`, `score_right` out SCORE_W: score counters.
- `point_scored` out 2: one-cycle pulse. Bit 1 = left player scored, bit 0 = right player scored.
- `game_over` out 1: high while in GAMEOVER.
- `winner` out 1: 1 = left won; valid while `game_over` is high.
- `state` out 3: current state, encoded with `pong_pkg::state_e`.

## Operation
The state machine has five states: IDLE → SERVE → PLAY → POINT → SERVE …, and PLAY/POINT → GAMEOVER.

- **IDLE:** ball is centred at (width/2, height/2) and velocity is 0. `start` clears both scores and the serve counter, then moves to SERVE.
- **SERVE:** the ball is held at centre. Each `frame_tick` increments the serve counter. When the counter reaches SERVE_FRAMES−1 on a tick, the state moves to PLAY and loads `vx = ±INIT_VX`, `vy = +INIT_VY`.
  - The first serve of a match goes toward the right (+).
  - Later serves go toward the player who conceded the last point.
- **PLAY:** each `frame_tick` computes nx = x+vx and ny = y+vy. Arithmetic is done in COORD_W+2 signed bits, with velocity sign-extended.
  - Top wall: if ny ≤ 0, set y = 0 and negate vy.
  - Bottom wall: if ny ≥ height−1, set y = height−1 and negate vy.
  - Left paddle hit: nx ≤ PADDLE_X and `left_paddle_y` ≤ y ≤ `left_paddle_y`+PADDLE_H−1 gives x = PADDLE_X and vx negated.
  - Right paddle hit: the same test mirrored at width−1−PADDLE_X, using `right_paddle_y`.
  - Left miss: nx ≤ 0 with no paddle hit scores for the right player.
  - Right miss: nx ≥ width−1 with no paddle hit scores for the left player.
  - Paddle checks take priority over miss checks. The wall and x results apply together in the same tick (corner case).
- **Point scored:** the scorer's counter increments and the matching `point_scored` bit pulses. If the new score equals WIN_SCORE, the state moves to GAMEOVER and `winner` is set. Otherwise it moves to POINT.
- **POINT:** lasts one cycle. It reloads the ball to centre, clears the serve counter, and moves to SERVE.
- **GAMEOVER:** the ball is frozen and the scores are held. `start` behaves as it does in IDLE.
- **AI paddle:** updates on every `frame_tick` in every state except IDLE.
  - Target = `ball_y` − PADDLE_H/2.
  - The paddle moves toward the target by at most AI_STEP.
  - The result is clamped to [0, height−PADDLE_H].
- **Scores:** scores never exceed WIN_SCORE and never wrap.

## Timing
- Every output is registered.
- Reset values:
  - `state` = IDLE.
  - All positions, velocities and scores = 0.
  - `point_scored` = 0, `game_over` = 0, `winner` = 0.
- Updates that follow a `frame_tick` appear in the cycle after the tick.
- `point_scored` is high for exactly one cycle, in the same cycle that `state` becomes POINT or GAMEOVER.
- A `frame_tick` that arrives while `state` = POINT is ignored.
- If `start` and `frame_tick` arrive in the same cycle in IDLE or GAMEOVER, `start` wins and the tick is not counted.
- `start` has no effect in SERVE, PLAY or POINT.
- `rst` asserted at any time, including mid-rally, returns the block to IDLE on the next edge with all reset values.
- `dimensions` is sampled on every tick. Changes mid-match take effect on the next tick.

## Structure
- `pong_pkg` holds:
  - `state_e` (IDLE, SERVE, PLAY, POINT, GAMEOVER, 3-bit).
  - `point_e` bit indices.
  - The `coord_t` and `vel_t` typedef helpers.
- Sub-module `pong_ai_paddle` implements the AI step-and-clamp logic. It is parametrised by COORD_W, PADDLE_H and AI_STEP, and has ports `clk`, `rst`, `frame_tick`, `enable`, `ball_y`, `height` and `paddle_y`.

## Test plan
- **Reset to IDLE:** reset, then `start` with `dimensions` = {640,480}. After 60 ticks, expect `state` = PLAY, ball at (320,240), vx = +3, vy = +2.
- **Wall bounce:** force ball y = 1 with vy = −2, then one tick. Expect y = 0 and vy = +2.
- **Right paddle hit:** ball at x = 629, vx = +3, `right_paddle_y` = 220, y = 240. Expect x = 631 (width−1−PADDLE_X) and vx = −3, with no `point_scored`.
- **Right miss:** same as above but `right_paddle_y` = 400. Run ticks until x crosses 639. Expect `point_scored` = 2'b10 for one cycle, `score_left` = 1, POINT then SERVE, and the next serve with vx = +3.
- **Match end:** left reaches 11 points. Expect `game_over` = 1, `winner` = 1, scores frozen at 11 and ticks ignored. Then `start` clears the scores.
- **Mid-rally reset:** assert `rst` mid-rally, with a simultaneous `start` + `frame_tick` in IDLE. Expect all reset values, and with the tick not counted expect PLAY to be reached after exactly 60 further ticks.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types for the pong game core: match states, point-pulse bit indices and
// default-width coordinate/velocity helpers.
package pong_pkg;

  localparam int unsigned CoordWDefault = 16;
  localparam int unsigned VelWDefault   = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameOver = 3'd4
  } state_e;

  typedef enum logic {
    PtRight = 1'b0,
    PtLeft  = 1'b1
  } point_e;

  typedef logic [CoordWDefault-1:0]      coord_t;
  typedef logic signed [VelWDefault-1:0] vel_t;

endpackage

// File: rtl/pong_ai_paddle.sv
// Computer-driven paddle: each enabled frame it steps toward the ball by at most AI_STEP,
// then clamps to the playfield.
module pong_ai_paddle #(
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned PADDLE_H = 32,
  parameter int unsigned AI_STEP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] height,
  output logic [COORD_W-1:0] paddle_y
);

  localparam int unsigned SW = COORD_W + 2;
  typedef logic signed [SW-1:0] wide_t;

  localparam wide_t Step = wide_t'(AI_STEP);
  localparam wide_t Half = wide_t'(PADDLE_H / 2);
  localparam wide_t Ph   = wide_t'(PADDLE_H);

  logic [COORD_W-1:0] paddle_q, paddle_d;
  wide_t cur, target, diff, moved, top_max;

  always_comb begin
    cur     = $signed({2'b00, paddle_q});
    target  = $signed({2'b00, ball_y}) - Half;
    diff    = target - cur;
    top_max = $signed({2'b00, height}) - Ph;

    if (diff > Step) begin
      moved = cur + Step;
    end else if (diff < -Step) begin
      moved = cur - Step;
    end else begin
      moved = target;
    end

    // Upper clamp first so a field shorter than the paddle pins it to 0.
    if (moved > top_max) moved = top_max;
    if (moved < wide_t'(0)) moved = wide_t'(0);

    paddle_d = paddle_q;
    if (frame_tick && enable) paddle_d = moved[COORD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddle_q <= '0;
    end else begin
      paddle_q <= paddle_d;
    end
  end

  assign paddle_y = paddle_q;

endmodule

// File: rtl/pong_match_engine.sv
// Frame-stepped pong core: ball kinematics, wall/paddle collisions, scoring and the
// IDLE/SERVE/PLAY/POINT/GAMEOVER match sequencer.
module pong_match_engine
  import pong_pkg::*;
#(
  parameter int unsigned COORD_W      = 16,
  parameter int unsigned VEL_W        = 8,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned PADDLE_H     = 32,
  parameter int unsigned PADDLE_X     = 8,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned AI_STEP      = 2,
  parameter int unsigned INIT_VX      = 3,
  parameter int unsigned INIT_VY      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic [2*COORD_W-1:0]      dimensions,
  input  logic [COORD_W-1:0]        right_paddle_y,
  output logic [COORD_W-1:0]        ball_x,
  output logic [COORD_W-1:0]        ball_y,
  output logic signed [VEL_W-1:0]   ball_vx,
  output logic signed [VEL_W-1:0]   ball_vy,
  output logic [COORD_W-1:0]        left_paddle_y,
  output logic [SCORE_W-1:0]        score_left,
  output logic [SCORE_W-1:0]        score_right,
  output logic [1:0]                point_scored,
  output logic                      game_over,
  output logic                      winner,
  output state_e                    state
);

  localparam int unsigned SW   = COORD_W + 2;
  localparam int unsigned CntW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  typedef logic signed [SW-1:0] wide_t;

  localparam logic [CntW-1:0]         ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0]      WinScore  = SCORE_W'(WIN_SCORE);
  localparam logic signed [VEL_W-1:0] InitVx    = VEL_W'(INIT_VX);
  localparam logic signed [VEL_W-1:0] InitVy    = VEL_W'(INIT_VY);
  localparam wide_t                   PadX      = wide_t'(PADDLE_X);
  localparam wide_t                   PadH      = wide_t'(PADDLE_H);

  function automatic wide_t widen(input logic [COORD_W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic wide_t widen_vel(input logic signed [VEL_W-1:0] v);
    return $signed({{(SW - VEL_W){v[VEL_W-1]}}, v});
  endfunction

  state_e                    state_q, state_d;
  logic [COORD_W-1:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic signed [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [SCORE_W-1:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CntW-1:0]           serve_cnt_q, serve_cnt_d;
  logic [1:0]                point_q, point_d;
  logic                      game_over_q, game_over_d;
  logic                      winner_q, winner_d;
  logic                      serve_right_q, serve_right_d;

  logic [COORD_W-1:0] width, height, centre_x, centre_y, left_paddle;
  wide_t  y_w, nx, ny, w_last, h_last, right_face, lp_top, rp_top;
  logic   hit_left, hit_right, miss_left, miss_right, left_scores, right_scores;
  logic   new_match, ai_enable;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  assign width    = dimensions[2*COORD_W-1:COORD_W];
  assign height   = dimensions[COORD_W-1:0];
  assign centre_x = width >> 1;
  assign centre_y = height >> 1;

  // Tick in POINT is dropped along with everything else that state ignores.
  assign ai_enable = (state_q == StServe) || (state_q == StPlay) || (state_q == StGameOver);

  pong_ai_paddle #(
    .COORD_W  (COORD_W),
    .PADDLE_H (PADDLE_H),
    .AI_STEP  (AI_STEP)
  ) u_ai_paddle (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (ai_enable),
    .ball_y     (ball_y_q),
    .height     (height),
    .paddle_y   (left_paddle)
  );

  always_comb begin
    y_w        = widen(ball_y_q);
    nx         = widen(ball_x_q) + widen_vel(vx_q);
    ny         = y_w + widen_vel(vy_q);
    w_last     = widen(width) - wide_t'(1);
    h_last     = widen(height) - wide_t'(1);
    right_face = w_last - PadX;
    lp_top     = widen(left_paddle);
    rp_top     = widen(right_paddle_y);

    hit_left   = (nx <= PadX) && (y_w >= lp_top) && (y_w <= lp_top + PadH - wide_t'(1));
    hit_right  = (nx >= right_face) && (y_w >= rp_top) && (y_w <= rp_top + PadH - wide_t'(1));
    miss_left  = (nx <= wide_t'(0));
    miss_right = (nx >= w_last);

    right_scores = !hit_left && !hit_right && miss_left;
    left_scores  = !hit_left && !hit_right && !miss_left && miss_right;

    score_l_inc = (score_l_q < WinScore) ? score_l_q + SCORE_W'(1) : score_l_q;
    score_r_inc = (score_r_q < WinScore) ? score_r_q + SCORE_W'(1) : score_r_q;
  end

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_cnt_d   = serve_cnt_q;
    point_d       = '0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    serve_right_d = serve_right_q;
    new_match     = 1'b0;

    unique case (state_q)
      StIdle: begin
        ball_x_d  = centre_x;
        ball_y_d  = centre_y;
        vx_d      = '0;
        vy_d      = '0;
        new_match = start;
      end
      StServe: begin
        ball_x_d = centre_x;
        ball_y_d = centre_y;
        if (frame_tick) begin
          if (serve_cnt_q == ServeLast) begin
            state_d = StPlay;
            vx_d    = serve_right_q ? InitVx : -InitVx;
            vy_d    = InitVy;
          end else begin
            serve_cnt_d = serve_cnt_q + CntW'(1);
          end
        end
      end
      StPlay: begin
        if (frame_tick) begin
          if (left_scores || right_scores) begin
            // Ball stays where it was; POINT recentres it, GAMEOVER freezes it.
            if (left_scores) begin
              score_l_d        = score_l_inc;
              point_d[PtLeft]  = 1'b1;
              serve_right_d    = 1'b1;
            end else begin
              score_r_d        = score_r_inc;
              point_d[PtRight] = 1'b1;
              serve_right_d    = 1'b0;
            end
            if ((left_scores && score_l_inc == WinScore) ||
                (right_scores && score_r_inc == WinScore)) begin
              state_d     = StGameOver;
              game_over_d = 1'b1;
              winner_d    = left_scores;
            end else begin
              state_d = StPoint;
            end
          end else begin
            if (ny <= wide_t'(0)) begin
              ball_y_d = '0;
              vy_d     = -vy_q;
            end else if (ny >= h_last) begin
              ball_y_d = h_last[COORD_W-1:0];
              vy_d     = -vy_q;
            end else begin
              ball_y_d = ny[COORD_W-1:0];
            end

            if (hit_left) begin
              ball_x_d = PadX[COORD_W-1:0];
              vx_d     = -vx_q;
            end else if (hit_right) begin
              ball_x_d = right_face[COORD_W-1:0];
              vx_d     = -vx_q;
            end else begin
              ball_x_d = nx[COORD_W-1:0];
            end
          end
        end
      end
      StPoint: begin
        ball_x_d    = centre_x;
        ball_y_d    = centre_y;
        vx_d        = '0;
        vy_d        = '0;
        serve_cnt_d = '0;
        state_d     = StServe;
      end
      StGameOver: begin
        new_match = start;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (new_match) begin
      state_d       = StServe;
      score_l_d     = '0;
      score_r_d     = '0;
      serve_cnt_d   = '0;
      game_over_d   = 1'b0;
      winner_d      = 1'b0;
      serve_right_d = 1'b1;
      ball_x_d      = centre_x;
      ball_y_d      = centre_y;
      vx_d          = '0;
      vy_d          = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ball_x_q      <= '0;
      ball_y_q      <= '0;
      vx_q          <= '0;
      vy_q          <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      serve_cnt_q   <= '0;
      point_q       <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      serve_right_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_cnt_q   <= serve_cnt_d;
      point_q       <= point_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      serve_right_q <= serve_right_d;
    end
  end

  assign ball_x        = ball_x_q;
  assign ball_y        = ball_y_q;
  assign ball_vx       = vx_q;
  assign ball_vy       = vy_q;
  assign left_paddle_y = left_paddle;
  assign score_left    = score_l_q;
  assign score_right   = score_r_q;
  assign point_scored  = point_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pong_match_engine.sv
// Directed bench for pong_match_engine: serve timing, walls, paddles, scoring, match end
// and mid-rally reset, with expected values worked out by hand.
module tb_pong_match_engine;
  import pong_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_tick;
  logic               start;
  logic [31:0]        dimensions;
  logic [15:0]        right_paddle_y;
  logic [15:0]        ball_x, ball_y, left_paddle_y;
  logic signed [7:0]  ball_vx, ball_vy;
  logic [7:0]         score_left, score_right;
  logic [1:0]         point_scored;
  logic               game_over, winner;
  state_e             state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_match_engine dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start          (start),
    .dimensions     (dimensions),
    .right_paddle_y (right_paddle_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_vx        (ball_vx),
    .ball_vy        (ball_vy),
    .left_paddle_y  (left_paddle_y),
    .score_left     (score_left),
    .score_right    (score_right),
    .point_scored   (point_scored),
    .game_over      (game_over),
    .winner         (winner),
    .state          (state)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state, StIdle);
    chk({tag, "_x"}, ball_x, 0);
    chk({tag, "_y"}, ball_y, 0);
    chk({tag, "_vx"}, ball_vx, 0);
    chk({tag, "_vy"}, ball_vy, 0);
    chk({tag, "_lp"}, left_paddle_y, 0);
    chk({tag, "_sl"}, score_left, 0);
    chk({tag, "_sr"}, score_right, 0);
    chk({tag, "_pt"}, point_scored, 0);
    chk({tag, "_go"}, game_over, 0);
    chk({tag, "_win"}, winner, 0);
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    frame_tick     = 1'b0;
    dimensions     = {16'd640, 16'd480};
    right_paddle_y = 16'd400;
    cyc();
    cyc();
    chk_reset("rst");

    rst = 1'b0;
    cyc();
    chk("idle_state", state, StIdle);
    chk("idle_cx", ball_x, 320);
    chk("idle_cy", ball_y, 240);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_state", state, StServe);

    ticks(59);
    chk("serve59_state", state, StServe);
    tick();
    chk("serve60_state", state, StPlay);
    chk("serve_x", ball_x, 320);
    chk("serve_y", ball_y, 240);
    chk("serve_vx", ball_vx, 3);
    chk("serve_vy", ball_vy, 2);
    chk("serve_lp", left_paddle_y, 120);

    // Rally 1: shrink height to 40 so ball bounces off bottom, then top.
    dimensions = {16'd640, 16'd40};
    tick();
    chk("bot_y", ball_y, 39);
    chk("bot_vy", ball_vy, -2);
    chk("bot_x", ball_x, 323);
    chk("bot_lp", left_paddle_y, 8);
    ticks(19);
    chk("pre_top_y", ball_y, 1);
    chk("pre_top_vy", ball_vy, -2);
    chk("pre_top_x", ball_x, 380);
    tick();
    chk("top_y", ball_y, 0);
    chk("top_vy", ball_vy, 2);
    chk("top_x", ball_x, 383);
    chk("top_lp", left_paddle_y, 0);

    dimensions = {16'd640, 16'd480};
    ticks(82);
    chk("r1_x103", ball_x, 629);
    chk("r1_y103", ball_y, 164);
    tick();
    chk("r1_x104", ball_x, 632);
    chk("r1_lp104", left_paddle_y, 148);
    chk("r1_pt104", point_scored, 0);
    ticks(2);
    chk("r1_x106", ball_x, 638);
    chk("r1_y106", ball_y, 170);
    tick();
    chk("miss_pt", point_scored, 2'b10);
    chk("miss_sl", score_left, 1);
    chk("miss_sr", score_right, 0);
    chk("miss_state", state, StPoint);
    tick();
    chk("point_next", state, StServe);
    chk("point_pulse_end", point_scored, 0);
    chk("point_cx", ball_x, 320);
    chk("point_cy", ball_y, 240);
    ticks(59);
    chk("s2_59_state", state, StServe);
    tick();
    chk("s2_state", state, StPlay);
    chk("s2_vx", ball_vx, 3);
    chk("s2_vy", ball_vy, 2);

    // Rally 2: right paddle covers y=446 at x=629.
    right_paddle_y = 16'd430;
    ticks(103);
    chk("r2_x103", ball_x, 629);
    chk("r2_y103", ball_y, 446);
    tick();
    chk("hit_x", ball_x, 631);
    chk("hit_vx", ball_vx, -3);
    chk("hit_y", ball_y, 448);
    chk("hit_pt", point_scored, 0);
    chk("hit_state", state, StPlay);

    dimensions     = {16'd600, 16'd480};
    right_paddle_y = 16'd400;
    tick();
    chk("narrow_pt", point_scored, 2'b10);
    chk("narrow_sl", score_left, 2);
    chk("narrow_x", ball_x, 631);
    chk("narrow_state", state, StPoint);
    dimensions = {16'd640, 16'd480};
    cyc();
    chk("narrow_next", state, StServe);

    for (int r = 3; r <= 11; r++) begin
      ticks(60);
      ticks(107);
      chk("loop_sl", score_left, r);
      chk("loop_pt", point_scored, 2'b10);
      if (r < 11) begin
        chk("loop_state", state, StPoint);
        cyc();
      end
    end
    chk("go_state", state, StGameOver);
    chk("go_flag", game_over, 1);
    chk("go_winner", winner, 1);
    chk("go_sl", score_left, 11);
    chk("go_sr", score_right, 0);
    chk("go_x", ball_x, 638);
    chk("go_y", ball_y, 452);
    ticks(3);
    chk("go_frz_state", state, StGameOver);
    chk("go_frz_x", ball_x, 638);
    chk("go_frz_y", ball_y, 452);
    chk("go_frz_sl", score_left, 11);
    chk("go_frz_pt", point_scored, 0);

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", state, StServe);
    chk("restart_sl", score_left, 0);
    chk("restart_go", game_over, 0);

    ticks(60);
    ticks(5);
    chk("mid_state", state, StPlay);
    chk("mid_x", ball_x, 335);
    rst = 1'b1;
    cyc();
    chk_reset("midrst");
    rst = 1'b0;
    cyc();
    start      = 1'b1;
    frame_tick = 1'b1;
    cyc();
    start      = 1'b0;
    frame_tick = 1'b0;
    chk("st_tick_state", state, StServe);
    chk("st_tick_lp", left_paddle_y, 0);
    ticks(59);
    chk("st_tick_59", state, StServe);
    tick();
    chk("st_tick_60", state, StPlay);
    chk("st_tick_lp60", left_paddle_y, 120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
